// File: rtl/sram_pkg.sv
// Shared defaults and FSM encoding for the async SRAM controller.
// Optional counters are enabled by defining SRAM_CTRL_STATS_EN.
package sram_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_TURN   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_SETUP  = ST_SETUP,
    S_ACCESS = ST_ACCESS,
    S_HOLD   = ST_HOLD,
    S_TURN   = ST_TURN
  } state_e;

endpackage

// File: rtl/sram_bus_io.sv
// Tri-state driver for the SRAM data bus plus the read capture register.
module sram_bus_io
  import sram_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              drive_en_i,
  input  logic [DATA_W-1:0] dout_i,
  input  logic              cap_en_i,
  input  logic [1:0]        cap_be_i,
  output logic [DATA_W-1:0] rdata_o,
  inout  wire  [DATA_W-1:0] bus
);

  localparam int LANE_W = DATA_W / 2;

  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] rdata_q;

  assign mask = {{LANE_W{cap_be_i[1]}}, {LANE_W{cap_be_i[0]}}};
  assign bus  = drive_en_i ? dout_i : 'z;

  // Disabled lanes read back as zero, whatever the SRAM leaves on them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (cap_en_i) begin
      rdata_q <= bus & mask;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_ctrl.sv
// Valid/ready request controller driving timed async SRAM cycles.
// Define SRAM_CTRL_STATS_EN to add saturating wr_count/rd_count outputs.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int ADDR_W   = SRAM_ADDR_W,
  parameter int DATA_W   = SRAM_DATA_W,
  parameter int WAIT_CYC = 2,
  parameter int TURN_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] bus,
  output logic              chip_enable,
  output logic              data_enable,
  output logic              output_enable,
  output logic              LB,
  output logic              UB
`ifdef SRAM_CTRL_STATS_EN
  ,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
`endif
);

  if (WAIT_CYC < 1) begin : g_bad_wait
    $error("sram_ctrl: WAIT_CYC must be >= 1");
  end
  if (TURN_CYC < 1) begin : g_bad_turn
    $error("sram_ctrl: TURN_CYC must be >= 1");
  end

  localparam int CNT_MAX = (WAIT_CYC > TURN_CYC) ? WAIT_CYC : TURN_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] TURN_LD = CNT_W'(TURN_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              wr_q;
  logic [1:0]        be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dout_q;
  logic              drive_q;
  logic              ce_q;
  logic              we_q;
  logic              oe_q;
  logic              lb_q;
  logic              ub_q;
  logic              ready_q;
  logic              rsp_q;

  logic accept;
  logic last_acc;
  logic cap_en;

  assign accept   = (state_q == S_IDLE) && req_valid && ready_q;
  assign last_acc = (state_q == S_ACCESS) && (cnt_q == '0);
  assign cap_en   = last_acc && !wr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      drive_q <= 1'b0;
      ce_q    <= 1'b1;
      we_q    <= 1'b1;
      oe_q    <= 1'b1;
      lb_q    <= 1'b1;
      ub_q    <= 1'b1;
      ready_q <= 1'b0;
      rsp_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          rsp_q   <= 1'b0;
          if (accept) begin
            ready_q <= 1'b0;
            state_q <= S_SETUP;
            wr_q    <= req_we;
            be_q    <= req_be;
            addr_q  <= req_addr;
            dout_q  <= req_wdata;
            lb_q    <= ~req_be[0];
            ub_q    <= ~req_be[1];
            ce_q    <= 1'b0;
            drive_q <= req_we;
            oe_q    <= req_we;
          end
        end
        S_SETUP: begin
          state_q <= S_ACCESS;
          cnt_q   <= WAIT_LD;
          if (wr_q) begin
            we_q <= 1'b0;
          end
        end
        S_ACCESS: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else if (wr_q) begin
            state_q <= S_HOLD;
            we_q    <= 1'b1;
          end else begin
            // Read data is captured on this edge by the bus block.
            state_q <= S_TURN;
            cnt_q   <= TURN_LD;
            ce_q    <= 1'b1;
            oe_q    <= 1'b1;
            rsp_q   <= 1'b1;
          end
        end
        S_HOLD: begin
          state_q <= S_IDLE;
          ce_q    <= 1'b1;
          drive_q <= 1'b0;
          lb_q    <= 1'b1;
          ub_q    <= 1'b1;
          ready_q <= 1'b1;
        end
        S_TURN: begin
          rsp_q <= 1'b0;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else begin
            state_q <= S_IDLE;
            lb_q    <= 1'b1;
            ub_q    <= 1'b1;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  sram_bus_io #(
    .DATA_W(DATA_W)
  ) u_io (
    .clk       (clk),
    .rst_n     (rst_n),
    .drive_en_i(drive_q),
    .dout_i    (dout_q),
    .cap_en_i  (cap_en),
    .cap_be_i  (be_q),
    .rdata_o   (rsp_rdata),
    .bus       (bus)
  );

  assign req_ready     = ready_q;
  assign rsp_valid     = rsp_q;
  assign address       = addr_q;
  assign chip_enable   = ce_q;
  assign data_enable   = we_q;
  assign output_enable = oe_q;
  assign LB            = lb_q;
  assign UB            = ub_q;

`ifdef SRAM_CTRL_STATS_EN
  logic [15:0] wr_cnt_q;
  logic [15:0] rd_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (state_q == S_HOLD && wr_cnt_q != 16'hFFFF) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
      if (rsp_q && rd_cnt_q != 16'hFFFF) begin
        rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end

  assign wr_count = wr_cnt_q;
  assign rd_count = rd_cnt_q;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: vector table, read scoreboard, per-cycle pin checks.
// Define SRAM_CTRL_STATS_EN to also exercise the access counters.
module tb_sram_ctrl;

  localparam int AW   = 20;
  localparam int DW   = 16;
  localparam int WAIT = 2;
  localparam int TURN = 1;
  localparam int NV   = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [1:0]    req_be;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] address;
  wire  [DW-1:0] bus;
  logic          chip_enable;
  logic          data_enable;
  logic          output_enable;
  logic          LB;
  logic          UB;
`ifdef SRAM_CTRL_STATS_EN
  logic [15:0]   wr_count;
  logic [15:0]   rd_count;
`endif

  always #5 clk = ~clk;

  sram_ctrl #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .WAIT_CYC(WAIT),
    .TURN_CYC(TURN)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_be       (req_be),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .address      (address),
    .bus          (bus),
    .chip_enable  (chip_enable),
    .data_enable  (data_enable),
    .output_enable(output_enable),
    .LB           (LB),
    .UB           (UB)
`ifdef SRAM_CTRL_STATS_EN
    ,
    .wr_count     (wr_count),
    .rd_count     (rd_count)
`endif
  );

  // Async SRAM model, aliased on the low address byte.
  logic [15:0] mem [0:255];

  assign bus = (!chip_enable && !output_enable && data_enable)
             ? mem[address[7:0]] : 'z;

  always @(posedge clk) begin
    if (!chip_enable && !data_enable) begin
      if (!LB) mem[address[7:0]][7:0]  <= bus[7:0];
      if (!UB) mem[address[7:0]][15:8] <= bus[15:8];
    end
  end

  typedef struct {
    logic        we;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp;
  } vec_t;

  vec_t        tbl [NV];
  logic [15:0] sb [$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          we_run = 0;
  logic        prev_rsp = 1'b0;
  logic        cur_we = 1'b0;
  logic [15:0] cur_wd = '0;
  logic [1:0]  cur_be = '0;
  logic [4:0]  pins;

  assign pins = {chip_enable, data_enable, output_enable, LB, UB};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    logic [1:0] nbe;
    logic [1:0] co;
    @(negedge clk);
    cyc++;
    if (rsp_valid) begin
      co = {chip_enable, output_enable};
      chk("rsp_pulse", 32'(prev_rsp), 32'd0);
      chk("rsp_latency", 32'(cyc - acc_cyc), 32'(WAIT + 1));
      chk("turn_pins", 32'(co), 32'h3);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got rdata %0h, expected no rsp",
                 rsp_rdata);
      end else begin
        checks--;
        chk("rsp_rdata", 32'(rsp_rdata), 32'(sb.pop_front()));
      end
    end
    prev_rsp = rsp_valid;
    if (!data_enable) begin
      we_run++;
      chk("wr_bus", 32'(bus), 32'(cur_wd));
    end else if (we_run != 0) begin
      chk("we_pulse", 32'(we_run), 32'(WAIT));
      we_run = 0;
    end
    if (!chip_enable) begin
      nbe = ~cur_be;
      chk("byte_sel", 32'({UB, LB}), 32'(nbe));
    end
    if (!output_enable) begin
      chk("bus_vs_oe", 32'(dut.drive_q), 32'd0);
    end
  endtask

  task automatic issue(input logic we, input logic [19:0] a,
                       input logic [15:0] wd, input logic [1:0] be,
                       input logic [15:0] exp, input bit hold,
                       output int lat);
    int n = 0;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    req_be    = be;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    lat = n;
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got ready 0, expected 1");
      req_valid = 1'b0;
      return;
    end
    cur_we = we;
    cur_wd = wd;
    cur_be = be;
    if (!we) sb.push_back(exp);
    tick();
    if (!we) acc_cyc = cyc;
    chk("ready_drop", 32'(req_ready), 32'd0);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_ready(input int exp, input string nm);
    int n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    chk(nm, 32'(n), 32'(exp));
  endtask

  initial begin
    int lat;
    tbl[0]  = '{1'b1, 20'hFFFFF, 16'h1234, 2'b11, 16'h0000};
    tbl[1]  = '{1'b0, 20'hFFFFF, 16'h0000, 2'b11, 16'h1234};
    tbl[2]  = '{1'b1, 20'h00010, 16'h0000, 2'b11, 16'h0000};
    tbl[3]  = '{1'b1, 20'h00010, 16'hABCD, 2'b01, 16'h0000};
    tbl[4]  = '{1'b0, 20'h00010, 16'h0000, 2'b11, 16'h00CD};
    tbl[5]  = '{1'b1, 20'h00020, 16'hABCD, 2'b11, 16'h0000};
    tbl[6]  = '{1'b0, 20'h00020, 16'h0000, 2'b10, 16'hAB00};
    tbl[7]  = '{1'b0, 20'h00020, 16'h0000, 2'b01, 16'h00CD};
    tbl[8]  = '{1'b0, 20'h00020, 16'h0000, 2'b00, 16'h0000};
    tbl[9]  = '{1'b1, 20'h00020, 16'hFFFF, 2'b00, 16'h0000};
    tbl[10] = '{1'b0, 20'h00020, 16'h0000, 2'b11, 16'hABCD};
    tbl[11] = '{1'b1, 20'h00030, 16'h0000, 2'b11, 16'h0000};
    tbl[12] = '{1'b1, 20'h00030, 16'h5AA5, 2'b10, 16'h0000};
    tbl[13] = '{1'b0, 20'h00030, 16'h0000, 2'b11, 16'h5A00};

    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    repeat (3) @(negedge clk);

    chk("rst_pins", 32'(pins), 32'h1F);
    chk("rst_addr", 32'(address), 32'd0);
    chk("rst_rsp_ready", 32'({rsp_valid, req_ready}), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_drive", 32'(dut.drive_q), 32'd0);
    rst_n = 1'b1;
    wait_ready(1, "ready_after_reset");

    for (int i = 0; i < NV; i++) begin
      issue(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be,
            tbl[i].exp, 1'b0, lat);
      wait_ready(tbl[i].we ? WAIT + 2 : WAIT + 1 + TURN,
                 tbl[i].we ? "wr_latency" : "rd_latency");
    end

    // Read then write with req_valid held high across both.
    issue(1'b0, 20'h00020, 16'h0000, 2'b11, 16'hABCD, 1'b1, lat);
    issue(1'b1, 20'h00050, 16'h7777, 2'b11, 16'h0000, 1'b0, lat);
    chk("b2b_gap", 32'(lat), 32'(WAIT + 1 + TURN));
    wait_ready(WAIT + 2, "wr_latency");
    issue(1'b0, 20'h00050, 16'h0000, 2'b11, 16'h7777, 1'b0, lat);
    wait_ready(WAIT + 1 + TURN, "rd_latency");

    // Reset during the write ACCESS state abandons the write.
    issue(1'b1, 20'h00040, 16'h1111, 2'b11, 16'h0000, 1'b0, lat);
    wait_ready(WAIT + 2, "wr_latency");
    issue(1'b1, 20'h00040, 16'h2222, 2'b11, 16'h0000, 1'b0, lat);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_pins", 32'(pins), 32'h1F);
    chk("midrst_rsp_ready", 32'({rsp_valid, req_ready}), 32'd0);
    chk("midrst_drive", 32'(dut.drive_q), 32'd0);
    we_run = 0;
    tick();
    tick();
    rst_n = 1'b1;
    wait_ready(1, "ready_after_midrst");
    issue(1'b0, 20'h00040, 16'h0000, 2'b11, 16'h1111, 1'b0, lat);
    wait_ready(WAIT + 1 + TURN, "rd_latency");

`ifdef SRAM_CTRL_STATS_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_ready(1, "ready_after_stats_rst");
    chk("stats_rst", {wr_count, rd_count}, 32'd0);
    for (int i = 0; i < 51; i++) begin
      issue(1'b1, 20'(32'h80 + i), 16'(i * 3 + 1), 2'b11, 16'h0000,
            1'b0, lat);
      wait_ready(WAIT + 2, "wr_latency");
    end
    for (int i = 0; i < 51; i++) begin
      issue(1'b0, 20'(32'h80 + i), 16'h0000, 2'b11, 16'(i * 3 + 1),
            1'b0, lat);
      wait_ready(WAIT + 1 + TURN, "rd_latency");
    end
    chk("wr_count", 32'(wr_count), 32'd51);
    chk("rd_count", 32'(rd_count), 32'd51);
    force dut.wr_cnt_q = 16'hFFFF;
    force dut.rd_cnt_q = 16'hFFFF;
    tick();
    release dut.wr_cnt_q;
    release dut.rd_cnt_q;
    issue(1'b1, 20'h00090, 16'h4242, 2'b11, 16'h0000, 1'b0, lat);
    wait_ready(WAIT + 2, "wr_latency");
    issue(1'b0, 20'h00090, 16'h0000, 2'b11, 16'h4242, 1'b0, lat);
    wait_ready(WAIT + 1 + TURN, "rd_latency");
    chk("wr_count_sat", 32'(wr_count), 32'h0000FFFF);
    chk("rd_count_sat", 32'(rd_count), 32'h0000FFFF);
`endif

    repeat (3) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
